// File: rtl/upp_pkg.sv
// Shared definitions for the uPP receive path: FSM states, error bit
// positions, default sync word and the running-checksum type.
package upp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_SYNC,
    DISCARD,
    NUM,
    PAYLOAD,
    CSUM,
    GAP
  } state_t;

  localparam int unsigned ERR_SYNC    = 0;
  localparam int unsigned ERR_CSUM    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_SEQ     = 3;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF5F5;

  localparam int unsigned CSUM_W = 16;
  typedef logic [CSUM_W-1:0] csum_t;

  // Modular word sum used for the frame checksum
  function automatic csum_t csumAdd(input csum_t acc, input logic [15:0] word);
    return acc + csum_t'(word);
  endfunction

endpackage

// File: rtl/upp_req_timer.sv
// Down-counter that times the request (oREQ high) and gap (oREQ low)
// windows. iLOAD presets the count; oDONE flags the last cycle of a window.
module upp_req_timer #(
  parameter int unsigned W = 9
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         iLOAD,
  input  logic [W-1:0] iLEN,
  output logic         oDONE
);

  logic [W-1:0] count;

  // Preload on iLOAD, otherwise count down and rest at zero
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count <= '0;
    end else if (iLOAD) begin
      count <= iLEN;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // A window loaded with N lasts exactly N cycles
  assign oDONE = (count <= W'(1));

endmodule

// File: rtl/upp_frame_rx.sv
// DSP-side uPP frame receiver: requests a frame from the bridge, checks
// sync / length / checksum (and optionally sequence), and streams the
// payload out with frame status.
// Optional feature: define UPP_RX_SEQ_CHECK_EN to enable frame-number
// sequence checking (oERR[3]); otherwise the frame number is ignored.
module upp_frame_rx
  import upp_pkg::*;
#(
  parameter logic [15:0] FRAME_WORDS = 16'd34,
  parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter logic [8:0]  REQ_LENGTH  = 9'd200,
  parameter logic [8:0]  GAP_LENGTH  = 9'd200,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [15:0] iDATA_UPP,
  input  logic        iENA,
  output logic        oREQ,
  output logic [15:0] oDATA,
  output logic        oVALID,
  output logic        oSOF,
  output logic        oEOF,
  output logic        oFRAME_OK,
  output logic [3:0]  oERR,
  output logic [15:0] oFRAME_CNT
);

  state_t      state;
  logic [15:0] s1Data;
  logic        s1Ena;
  csum_t       sum;
  logic [15:0] payIdx;
  logic [15:0] toCnt;
  logic        timerLoad;
  logic [8:0]  timerLen;
  logic        timerDone;
  logic        csumOk;
  logic        seqBad;
  logic        lastPay;
  logic        toHit;

`ifdef UPP_RX_SEQ_CHECK_EN
  logic [15:0] frameNum;
  logic [15:0] expNum;
  logic        seqKnown;
  assign seqBad = seqKnown && (frameNum != expNum);
`else
  assign seqBad = 1'b0;
`endif

  assign csumOk  = (s1Data == sum);
  assign lastPay = (payIdx == FRAME_WORDS - 16'd4);
  assign toHit   = (toCnt == TIMEOUT - 16'd1);

  // Input stage: every decision is taken on the registered word/enable
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1Data <= '0;
      s1Ena  <= 1'b0;
    end else begin
      s1Data <= iDATA_UPP;
      s1Ena  <= iENA;
    end
  end

  // Timer stays preloaded outside REQ/GAP so every entry into GAP starts a
  // full window without the FSM having to name each entry path.
  always_comb begin
    timerLoad = 1'b1;
    timerLen  = GAP_LENGTH;
    case (state)
      IDLE:    timerLen = REQ_LENGTH;
      REQ:     timerLoad = 1'b0;
      GAP: begin
        timerLoad = timerDone;
        timerLen  = REQ_LENGTH;
      end
      default: ;
    endcase
  end

  upp_req_timer #(.W(9)) uTimer (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iLOAD (timerLoad),
    .iLEN  (timerLen),
    .oDONE (timerDone)
  );

  // Frame FSM with registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      oREQ       <= 1'b0;
      oDATA      <= '0;
      oVALID     <= 1'b0;
      oSOF       <= 1'b0;
      oEOF       <= 1'b0;
      oFRAME_OK  <= 1'b0;
      oERR       <= '0;
      oFRAME_CNT <= '0;
      sum        <= '0;
      payIdx     <= '0;
      toCnt      <= '0;
`ifdef UPP_RX_SEQ_CHECK_EN
      frameNum   <= '0;
      expNum     <= '0;
      seqKnown   <= 1'b0;
`endif
    end else begin
      oREQ      <= (state == REQ);
      oVALID    <= 1'b0;
      oSOF      <= 1'b0;
      oEOF      <= 1'b0;
      oFRAME_OK <= 1'b0;
      oERR      <= '0;
      case (state)
        IDLE: state <= REQ;
        REQ, WAIT_SYNC: begin
          if (s1Ena) begin
            if (s1Data == SYNC_WORD) begin
              state <= NUM;
              toCnt <= '0;
            end else begin
              oERR[ERR_SYNC] <= 1'b1;
              state          <= DISCARD;
            end
          end else if (state == REQ && timerDone) begin
            state <= WAIT_SYNC;
          end
        end
        DISCARD: if (!s1Ena) state <= GAP;
        NUM, PAYLOAD, CSUM: begin
          if (s1Ena) begin
            toCnt <= '0;
            if (state == NUM) begin
`ifdef UPP_RX_SEQ_CHECK_EN
              frameNum <= s1Data;
`endif
              sum    <= '0;
              payIdx <= '0;
              state  <= PAYLOAD;
            end else if (state == PAYLOAD) begin
              oDATA  <= s1Data;
              oVALID <= 1'b1;
              oSOF   <= (payIdx == '0);
              oEOF   <= lastPay;
              sum    <= csumAdd(sum, s1Data);
              payIdx <= payIdx + 16'd1;
              if (lastPay) state <= CSUM;
            end else begin
              oERR[ERR_CSUM] <= !csumOk;
              oERR[ERR_SEQ]  <= seqBad;
              if (csumOk && !seqBad) begin
                oFRAME_OK  <= 1'b1;
                oFRAME_CNT <= oFRAME_CNT + 16'd1;
              end
`ifdef UPP_RX_SEQ_CHECK_EN
              if (csumOk) begin
                expNum   <= frameNum + 16'd1;
                seqKnown <= 1'b1;
              end
`endif
              state <= GAP;
            end
          end else if (toHit) begin
            oERR[ERR_TIMEOUT] <= 1'b1;
            oEOF  <= (state == CSUM) || (state == PAYLOAD && payIdx != '0);
            toCnt <= '0;
            state <= GAP;
          end else begin
            toCnt <= toCnt + 16'd1;
          end
        end
        GAP: if (timerDone) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upp_frame_rx.sv
// Self-checking bench for upp_frame_rx: directed frame scenarios with
// random payloads, checked against a frame-level reference model.
module tb_upp_frame_rx;

  localparam int          FW      = 34;
  localparam logic [15:0] SYNC    = 16'hF5F5;
  localparam int          GAP_LEN = 200;
  localparam int          TMO     = 4096;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iDATA_UPP = '0;
  logic        iENA = 1'b0;
  logic        oREQ;
  logic [15:0] oDATA;
  logic        oVALID;
  logic        oSOF;
  logic        oEOF;
  logic        oFRAME_OK;
  logic [3:0]  oERR;
  logic [15:0] oFRAME_CNT;

  upp_frame_rx dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iDATA_UPP (iDATA_UPP),
    .iENA      (iENA),
    .oREQ      (oREQ),
    .oDATA     (oDATA),
    .oVALID    (oVALID),
    .oSOF      (oSOF),
    .oEOF      (oEOF),
    .oFRAME_OK (oFRAME_OK),
    .oERR      (oERR),
    .oFRAME_CNT(oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  int nCmp = 0;
  int nErr = 0;

  logic [17:0] gotQ[$];
  logic [3:0]  errQ[$];
  int          okCnt = 0;
  int          toEof = 0;
  int          stray = 0;
  logic [15:0] txQ[$];

  logic [15:0] mLast = '0;
  bit          mKnown = 1'b0;
  logic [15:0] mCnt = '0;

  // Output monitor, sampled away from the active edge
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oVALID) gotQ.push_back({oSOF, oEOF, oDATA});
      if (oFRAME_OK) okCnt++;
      if (oERR != 4'b0000) errQ.push_back(oERR);
      if (oEOF && !oVALID) toEof++;
      if (oSOF && !oVALID) stray++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    assert (got === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitReq(input string tag);
    int k;
    k = 0;
    while (oREQ !== 1'b1 && k < 2000) begin
      @(negedge iCLK);
      k++;
    end
    check({tag, ".req"}, {31'b0, oREQ}, 32'd1);
  endtask

  task automatic drive(input int pauseAfter, input int pauseLen);
    for (int i = 0; i < txQ.size(); i++) begin
      @(posedge iCLK); #1;
      iENA = 1'b1;
      iDATA_UPP = txQ[i];
      if (i == pauseAfter) begin
        @(posedge iCLK); #1;
        iENA = 1'b0;
        iDATA_UPP = 16'($urandom);
        repeat (pauseLen - 1) @(posedge iCLK);
      end
    end
    @(posedge iCLK); #1;
    iENA = 1'b0;
    iDATA_UPP = 16'($urandom);
  endtask

  task automatic buildFrame(input logic [15:0] num, input bit rnd, input bit badSum, input int extras);
    logic [15:0] s;
    logic [15:0] w;
    s = '0;
    txQ.delete();
    txQ.push_back(SYNC);
    txQ.push_back(num);
    for (int i = 0; i < FW - 3; i++) begin
      w = rnd ? 16'($urandom) : 16'(i);
      s = s + w;
      txQ.push_back(w);
    end
    txQ.push_back(badSum ? s - 16'd1 : s);
    for (int i = 0; i < extras; i++) txQ.push_back(16'($urandom));
  endtask

  task automatic runFrame(input string tag, input int late, input int pauseAfter, input int pauseLen);
    int          g0, e0, o0, t0, nPay;
    logic [15:0] s;
    logic [3:0]  eErr;
    bit          syncOk;
    waitReq(tag);
    repeat (late) @(negedge iCLK);
    g0 = gotQ.size(); e0 = errQ.size(); o0 = okCnt; t0 = toEof;
    drive(pauseAfter, pauseLen);
    repeat (6) @(negedge iCLK);
    syncOk = (txQ[0] == SYNC);
    eErr = '0;
    nPay = 0;
    if (!syncOk) begin
      eErr[0] = 1'b1;
    end else begin
      nPay = FW - 3;
      s = '0;
      for (int i = 0; i < nPay; i++) s = s + txQ[2+i];
      if (s != txQ[FW-1]) eErr[1] = 1'b1;
`ifdef UPP_RX_SEQ_CHECK_EN
      if (mKnown && txQ[1] != 16'(mLast + 16'd1)) eErr[3] = 1'b1;
`endif
      if (!eErr[1]) begin
        mLast = txQ[1];
        mKnown = 1'b1;
      end
      if (eErr == 4'b0000) mCnt++;
    end
    check({tag, ".words"}, gotQ.size() - g0, nPay);
    for (int i = 0; i < nPay && g0 + i < gotQ.size(); i++)
      check({tag, ".word"}, {14'b0, gotQ[g0+i]}, {14'b0, i == 0, i == nPay - 1, txQ[2+i]});
    check({tag, ".nerr"}, errQ.size() - e0, (eErr != 4'b0000) ? 1 : 0);
    if (errQ.size() > e0) check({tag, ".err"}, {28'b0, errQ[e0]}, {28'b0, eErr});
    check({tag, ".ok"}, okCnt - o0, (syncOk && eErr == 4'b0000) ? 1 : 0);
    check({tag, ".toeof"}, toEof - t0, 0);
    check({tag, ".cnt"}, {16'b0, oFRAME_CNT}, {16'b0, mCnt});
  endtask

  initial begin
    int  k, r, g0, e0, o0, t0;
    bit  seenLow;

    // Reset state and first request
    iRST_N = 1'b0;
    #12;
    check("rst.outs", {oREQ, oDATA, oVALID, oSOF, oEOF, oFRAME_OK, oERR, oFRAME_CNT}, '0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    check("rst.req0", {31'b0, oREQ}, 32'd0);
    @(negedge iCLK);
    check("rst.req1", {31'b0, oREQ}, 32'd1);

    // Directed good frame, then the same frame with a wrong checksum
    buildFrame(16'd1, 1'b0, 1'b0, 0);
    check("f1.csumword", {16'b0, txQ[FW-1]}, 32'h01D1);
    runFrame("f1", 0, -1, 0);
    buildFrame(16'd1, 1'b0, 1'b1, 0);
    runFrame("f1bad", 0, -1, 0);

    // Wrong sync word: error latency and request re-rise timing
    waitReq("sync");
    g0 = gotQ.size(); o0 = okCnt;
    txQ.delete();
    txQ.push_back(16'h1234);
    drive(-1, 0);
    k = 0;
    do begin
      @(negedge iCLK);
      k++;
    end while (oERR == 4'b0000 && k < 20);
    check("sync.lat", k, 2);
    check("sync.err", {28'b0, oERR}, 32'b0001);
    r = 0;
    seenLow = 1'b0;
    while (!(seenLow && oREQ === 1'b1) && r < 1000) begin
      @(negedge iCLK);
      r++;
      if (oREQ === 1'b0) seenLow = 1'b1;
    end
    check("sync.reqgap", r, GAP_LEN + 2);
    check("sync.novalid", gotQ.size() - g0, 0);
    check("sync.nook", okCnt - o0, 0);

    // Sync arriving after the request window closed, trailing extra words
    buildFrame(16'd2, 1'b1, 1'b0, 3);
    runFrame("late", 250, -1, 0);

    // Longest legal idle gap inside the payload
    buildFrame(16'd3, 1'b1, 1'b0, 0);
    runFrame("pause", 0, 11, TMO - 1);

    // Timeout after the 10th payload word
    buildFrame(16'd4, 1'b1, 1'b0, 0);
    txQ = txQ[0:11];
    waitReq("tmo");
    g0 = gotQ.size(); e0 = errQ.size(); o0 = okCnt; t0 = toEof;
    drive(-1, 0);
    k = 0;
    do begin
      @(negedge iCLK);
      k++;
    end while (oERR == 4'b0000 && k < TMO + 100);
    check("tmo.lat", k, TMO + 2);
    check("tmo.err", {28'b0, oERR}, 32'b0100);
    check("tmo.eofnv", {30'b0, oEOF, oVALID}, 32'b10);
    repeat (6) @(negedge iCLK);
    check("tmo.words", gotQ.size() - g0, 10);
    for (int i = 0; i < 10 && g0 + i < gotQ.size(); i++)
      check("tmo.word", {14'b0, gotQ[g0+i]}, {14'b0, i == 0, 1'b0, txQ[2+i]});
    check("tmo.nerr", errQ.size() - e0, 1);
    check("tmo.ok", okCnt - o0, 0);
    check("tmo.toeof", toEof - t0, 1);
    check("tmo.cnt", {16'b0, oFRAME_CNT}, {16'b0, mCnt});

    buildFrame(16'd4, 1'b1, 1'b0, 0);
    runFrame("after_tmo", 0, -1, 0);

    // Sequence pattern with a skipped number, then a corrupt checksum
    buildFrame(16'd5, 1'b1, 1'b0, 0);
    runFrame("seq5", 0, -1, 0);
    buildFrame(16'd6, 1'b1, 1'b0, 0);
    runFrame("seq6", 0, -1, 0);
    buildFrame(16'd8, 1'b1, 1'b0, 0);
    runFrame("seq8", 0, -1, 0);
    buildFrame(16'd9, 1'b1, 1'b0, 0);
    runFrame("seq9", 0, -1, 0);
    buildFrame(16'd10, 1'b1, 1'b1, 0);
    runFrame("rndbad", 0, -1, 0);

    // Reset in the middle of a payload
    buildFrame(16'($urandom), 1'b1, 1'b0, 0);
    waitReq("mid");
    for (int i = 0; i < 9; i++) begin
      @(posedge iCLK); #1;
      iENA = 1'b1;
      iDATA_UPP = txQ[i];
    end
    @(negedge iCLK);
    check("mid.prevalid", {31'b0, oVALID}, 32'd1);
    #1;
    iRST_N = 1'b0;
    #1;
    check("mid.outs", {oREQ, oDATA, oVALID, oSOF, oEOF, oFRAME_OK, oERR, oFRAME_CNT}, '0);
    iENA = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    mKnown = 1'b0;
    mLast = '0;
    mCnt = '0;
    buildFrame(16'($urandom), 1'b1, 1'b0, 0);
    runFrame("postrst", 0, -1, 0);

    check("stray.sof", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  // Bound on total run time
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion expected completion before time limit");
    $fatal(1, "watchdog");
  end

endmodule
